pdp8_panel_ctrl: RTL and testbench
==================================

# pdp8_panel_ctrl

Front-panel controller between the board push-buttons and the PDP-8 CPU switch inputs. It synchronizes and debounces the two active-low buttons. It turns a BUT2 press into an ordered RESET-then-CLEAR pulse sequence, and a BUT1 press into a single RUN or HALT pulse depending on CPU state. It sits in the top level between the button pins and the CPU's sw_RESET/sw_CLEAR/sw_RUN/sw_HALT inputs, clocked by the divided CPU clock.

## Interface

Parameters:
- DEBOUNCE_TICKS, 4: consecutive TICK samples of a new synchronized level required before the debounced state changes (≥1).
- RST_CYCLES, 8: CLK cycles sw_RESET is held high (≥1).
- CLR_CYCLES, 2: CLK cycles sw_CLEAR is held high after sw_RESET drops (≥1).

Ports:
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  one-CLK debounce sample strobe, from the refresh divider.
- nBUT1  in  1  RUN/HALT button, active low, asynchronous.
- nBUT2  in  1  reset button, active low, asynchronous.
- cpu_RUNNING  in  1  CPU run flag; sampled in IDLE.
- sw_RESET  out  1  registered; CPU reset.
- sw_CLEAR  out  1  registered; CPU clear.
- sw_RUN  out  1  registered one-cycle pulse.
- sw_HALT  out  1  registered one-cycle pulse.
- BUSY  out  1  high whenever FSM ≠ IDLE.

## Operation

- Each button passes through a 2-flop synchronizer with reset value 1 (released).
- Debounce, per button:
  - Counter width $clog2(DEBOUNCE_TICKS+1).
  - Counter clears whenever the synchronized level equals the debounced level.
  - Counter increments on TICK while the levels differ.
  - On the TICK where it would reach DEBOUNCE_TICKS, the debounced level flips and the counter clears.
  - Between TICKs the counter holds.
- Press event: a one-cycle internal pulse in the cycle after the debounced level goes 1→0. Releases generate no event.
- FSM states: IDLE, RST, CLR, plus START when PANEL_AUTOSTART_EN is defined.
  - IDLE + BUT2 event → RST, load cycle counter RST_CYCLES.
  - RST: sw_RESET=1; counter decrements each cycle; at 1 → CLR, load CLR_CYCLES.
  - CLR: sw_CLEAR=1; at count 1 → IDLE, or START if the macro is defined.
  - START: sw_RUN=1 for one cycle → IDLE.
  - IDLE + BUT1 event: cpu_RUNNING=1 → sw_HALT pulse for one cycle; cpu_RUNNING=0 → sw_RUN pulse for one cycle. FSM stays in IDLE.
- Simultaneous BUT1 and BUT2 events in IDLE: BUT2 wins; the BUT1 event is discarded.
- Events arriving while not in IDLE are discarded, not queued.
- sw_RESET and sw_CLEAR are never high in the same cycle. sw_RUN and sw_HALT are never high together.
- Reset, including mid-sequence: FSM→IDLE; all outputs 0; synchronizers and debounced levels → 1; debounce and cycle counters → 0. A button held through reset is therefore seen as a new press once debounced.

## Timing

- Output latency: an output rises on the 2nd CLK edge after the edge on which the debounced level flips. Edge 1 registers the event; edge 2 registers the FSM/output.
- Input to debounced flip: 2 sync cycles plus DEBOUNCE_TICKS TICK strobes of a stable level.
- BUT2 sequence, from the first sw_RESET cycle:
  - sw_RESET high for exactly RST_CYCLES cycles.
  - sw_CLEAR high for exactly CLR_CYCLES cycles, starting in the next cycle.
  - With autostart, sw_RUN is high for 1 cycle immediately after.
  - No gap cycles between phases.
- BUSY rises with the first sw_RESET cycle and falls in the first IDLE cycle.
- A glitch shorter than DEBOUNCE_TICKS TICK periods never changes the debounced level.

## Configuration

- PANEL_AUTOSTART_EN defined:
  - START state exists.
  - Every completed RESET/CLEAR sequence ends with a one-cycle sw_RUN pulse, regardless of cpu_RUNNING.
  - BUSY covers the START cycle.
- PANEL_AUTOSTART_EN undefined:
  - No START state; CLR returns directly to IDLE.
  - sw_RUN is produced only by BUT1.

## Test plan

Defaults apply unless stated; TICK every 4 CLK.

- Reset, then idle 100 cycles with both buttons released → all outputs 0, BUSY 0.
- nBUT2 low and held → sw_RESET high for 8 cycles, then sw_CLEAR high for 2 cycles, then BUSY 0. With PANEL_AUTOSTART_EN, one sw_RUN cycle follows; without it, sw_RUN stays 0.
- nBUT1 low with cpu_RUNNING=0 → exactly one sw_RUN cycle. Repeat after a release with cpu_RUNNING=1 → exactly one sw_HALT cycle.
- nBUT1 pulsed low for 3 TICK periods, then released → no output activity.
- Both buttons pressed on the same cycle → RESET/CLEAR sequence only; no sw_RUN or sw_HALT.
- RESET asserted on the 4th sw_RESET cycle → next cycle all outputs 0 and FSM in IDLE. With nBUT2 still held, a fresh full 8+2 sequence starts after re-debounce.

Source files
------------

// File: rtl/pdp8_panel_ctrl_if.sv
// pdp8_panel_ctrl_if
// Groups the front-panel button inputs, the debounce strobe, the CPU run
// flag and the CPU switch outputs of the panel controller.
//   master : the panel controller (drives sw_* and BUSY)
//   slave  : the CPU / board side (drives buttons, TICK, cpu_RUNNING)
// Signals:
//   TICK        debounce sample strobe, one CLK wide
//   nBUT1       RUN/HALT button, active low, asynchronous
//   nBUT2       reset button, active low, asynchronous
//   cpu_RUNNING CPU run flag
//   sw_RESET    CPU reset switch
//   sw_CLEAR    CPU clear switch
//   sw_RUN      CPU run pulse
//   sw_HALT     CPU halt pulse
//   BUSY        RESET/CLEAR sequence in progress
interface pdp8_panel_ctrl_if;
  logic TICK;
  logic nBUT1;
  logic nBUT2;
  logic cpu_RUNNING;
  logic sw_RESET;
  logic sw_CLEAR;
  logic sw_RUN;
  logic sw_HALT;
  logic BUSY;

  modport master (
    input  TICK, nBUT1, nBUT2, cpu_RUNNING,
    output sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, BUSY
  );

  modport slave (
    output TICK, nBUT1, nBUT2, cpu_RUNNING,
    input  sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, BUSY
  );
endinterface

// File: rtl/pdp8_panel_ctrl.sv
// pdp8_panel_ctrl
// Front-panel controller: synchronizes and debounces the two active-low
// push-buttons, turns a BUT2 press into a RESET-then-CLEAR pulse sequence
// and a BUT1 press into a single RUN or HALT pulse depending on cpu_RUNNING.
// Ports:
//   CLK    system clock (single domain)
//   RESET  synchronous active-high reset
//   pif    pdp8_panel_ctrl_if.master (buttons, TICK, cpu_RUNNING in;
//          sw_RESET/sw_CLEAR/sw_RUN/sw_HALT/BUSY out, all registered)
// Configuration macro:
//   PANEL_AUTOSTART_EN  when defined, every RESET/CLEAR sequence ends with a
//                       one-cycle sw_RUN pulse (START state).
module pdp8_panel_ctrl #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int RST_CYCLES     = 8,
  parameter int CLR_CYCLES     = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  pdp8_panel_ctrl_if.master  pif
);

  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int CMAX = (RST_CYCLES > CLR_CYCLES) ? RST_CYCLES : CLR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_ZERO  = DW'(0);
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RST   = 2'd1,
`ifdef PANEL_AUTOSTART_EN
    ST_CLR   = 2'd2,
    ST_START = 2'd3
`else
    ST_CLR   = 2'd2
`endif
  } state_t;

  // Bit 0 = BUT1 (run/halt), bit 1 = BUT2 (reset); level 1 = released.
  logic [1:0]         but_raw_s;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         deb_q, deb_d;
  logic [1:0]         prev_q;
  logic [1:0]         ev_q, ev_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               reset_q, reset_d;
  logic               clear_q, clear_d;
  logic               run_q, run_d;
  logic               halt_q, halt_d;
  logic               busy_q, busy_d;

  assign but_raw_s = {pif.nBUT2, pif.nBUT1};

  // Debounce next-state: a differing synchronized level must persist for
  // DEBOUNCE_TICKS strobes before the debounced level follows it.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        dcnt_d[b] = DB_ZERO;
      end else if (pif.TICK) begin
        if (dcnt_q[b] == DB_LAST) begin
          deb_d[b]  = sync2_q[b];
          dcnt_d[b] = DB_ZERO;
        end else begin
          dcnt_d[b] = dcnt_q[b] + DB_ONE;
        end
      end else begin
        dcnt_d[b] = dcnt_q[b];
      end
    end
    // Press event one cycle after the debounced 1->0 flip.
    ev_d = prev_q & ~deb_q;
  end

  // Synchronizers, debounced levels and press-event registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      prev_q  <= 2'b11;
      ev_q    <= 2'b00;
      dcnt_q  <= {2{DB_ZERO}};
    end else begin
      sync1_q <= but_raw_s;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      ev_q    <= ev_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Sequencer next-state; outputs are decoded from the next state so they
  // are registered together with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = 1'b0;
    halt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // BUT2 has priority; a simultaneous BUT1 event is dropped.
        if (ev_q[1]) begin
          state_d = ST_RST;
          cnt_d   = RST_LOAD;
        end else if (ev_q[0]) begin
          if (pif.cpu_RUNNING) begin
            halt_d = 1'b1;
          end else begin
            run_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RST: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CLR;
          cnt_d   = CLR_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CLR: begin
        if (cnt_q == CNT_ONE) begin
`ifdef PANEL_AUTOSTART_EN
          state_d = ST_START;
`else
          state_d = ST_IDLE;
`endif
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef PANEL_AUTOSTART_EN
      ST_START: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    reset_d = (state_d == ST_RST);
    clear_d = (state_d == ST_CLR);
    busy_d  = (state_d != ST_IDLE);
`ifdef PANEL_AUTOSTART_EN
    if (state_d == ST_START) begin
      run_d = 1'b1;
    end else begin
      run_d = run_d;
    end
`endif
  end

  // Sequencer state, cycle counter and registered switch outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      reset_q <= 1'b0;
      clear_q <= 1'b0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
      clear_q <= clear_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
    end
  end

  assign pif.sw_RESET = reset_q;
  assign pif.sw_CLEAR = clear_q;
  assign pif.sw_RUN   = run_q;
  assign pif.sw_HALT  = halt_q;
  assign pif.BUSY     = busy_q;

endmodule

// File: tb/tb_pdp8_panel_ctrl.sv
// Testbench for pdp8_panel_ctrl: directed scenarios plus a randomized phase,
// every cycle compared against a cycle-indexed expectation table built from
// the button history by a behavioural model.
module tb_pdp8_panel_ctrl;
  localparam int DT   = 4;
  localparam int RC   = 8;
  localparam int CC   = 2;
  localparam int MAXC = 8192;
`ifdef PANEL_AUTOSTART_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  pdp8_panel_ctrl_if pif();

  pdp8_panel_ctrl #(
    .DEBOUNCE_TICKS(DT),
    .RST_CYCLES(RC),
    .CLR_CYCLES(CC)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .pif(pif)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: edge counter, raw input history, expected outputs per cycle.
  int  n        = 0;
  int  last_rst = 0;
  int  tick_ph  = 0;
  bit  rand_tick = 1'b0;
  bit  raw1 [MAXC];
  bit  raw2 [MAXC];
  bit  ev1_at [MAXC];
  bit  ev2_at [MAXC];
  bit  e_rst  [MAXC];
  bit  e_clr  [MAXC];
  bit  e_run  [MAXC];
  bit  e_halt [MAXC];
  bit  e_busy [MAXC];
  bit  mdeb [2];
  int  mcnt [2];
  int  o_rst, o_clr, o_run, o_halt, o_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [4:0] dut_out();
    return {pif.sw_RESET, pif.sw_CLEAR, pif.sw_RUN, pif.sw_HALT, pif.BUSY};
  endfunction

  task automatic clr_counts();
    o_rst = 0; o_clr = 0; o_run = 0; o_halt = 0; o_busy = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit lvl;
    n++;
    raw1[n] = pif.nBUT1;
    raw2[n] = pif.nBUT2;
    if (RESET) begin
      last_rst = n;
      mdeb[0] = 1'b1; mdeb[1] = 1'b1;
      mcnt[0] = 0;    mcnt[1] = 0;
      for (int c = n; c < n + 24; c++) begin
        ev1_at[c] = 1'b0; ev2_at[c] = 1'b0;
        e_rst[c] = 1'b0; e_clr[c] = 1'b0; e_run[c] = 1'b0;
        e_halt[c] = 1'b0; e_busy[c] = 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        // Level seen by the debouncer is the raw input two edges ago.
        if (n - 2 > last_rst) lvl = (b == 0) ? raw1[n-2] : raw2[n-2];
        else lvl = 1'b1;
        if (lvl == mdeb[b]) begin
          mcnt[b] = 0;
        end else if (pif.TICK) begin
          mcnt[b]++;
          if (mcnt[b] == DT) begin
            mdeb[b] = lvl;
            mcnt[b] = 0;
            if (!lvl) begin
              if (b == 0) ev1_at[n+2] = 1'b1;
              else        ev2_at[n+2] = 1'b1;
            end
          end
        end
      end
      if (!e_busy[n-1]) begin
        if (ev2_at[n]) begin
          for (int i = 0; i < RC; i++) begin
            e_rst[n+i] = 1'b1; e_busy[n+i] = 1'b1;
          end
          for (int i = 0; i < CC; i++) begin
            e_clr[n+RC+i] = 1'b1; e_busy[n+RC+i] = 1'b1;
          end
          if (AUTO != 0) begin
            e_run[n+RC+CC] = 1'b1; e_busy[n+RC+CC] = 1'b1;
          end
        end else if (ev1_at[n]) begin
          if (pif.cpu_RUNNING) e_halt[n] = 1'b1;
          else                 e_run[n]  = 1'b1;
        end
      end
    end
  endtask

  // One clock: model at the edge, compare at the falling edge, set next TICK.
  task automatic step();
    logic [4:0] got;
    logic [4:0] exp;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    got = dut_out();
    exp = {e_rst[n], e_clr[n], e_run[n], e_halt[n], e_busy[n]};
    chk("outputs_vs_model", {27'd0, got}, {27'd0, exp});
    chk("exclusive_pairs", {31'd0, (got[4] & got[3]) | (got[2] & got[1])}, 32'd0);
    o_rst  += int'(got[4]);
    o_clr  += int'(got[3]);
    o_run  += int'(got[2]);
    o_halt += int'(got[1]);
    o_busy += int'(got[0]);
    tick_ph++;
    if (rand_tick) pif.TICK = ($urandom_range(0, 3) == 0);
    else           pif.TICK = ((tick_ph % 4) == 0);
  endtask

  initial begin
    int k;
    int len;
    pif.TICK = 1'b0;
    pif.nBUT1 = 1'b1;
    pif.nBUT2 = 1'b1;
    pif.cpu_RUNNING = 1'b0;
    RESET = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    chk("reset_state", {27'd0, dut_out()}, 32'd0);

    // Idle with both buttons released.
    clr_counts();
    repeat (100) step();
    chk("idle_activity", o_rst + o_clr + o_run + o_halt + o_busy, 0);

    // BUT2 press and hold.
    clr_counts();
    pif.nBUT2 = 1'b0;
    repeat (80) step();
    chk("but2_reset_len", o_rst, RC);
    chk("but2_clear_len", o_clr, CC);
    chk("but2_run_cnt", o_run, AUTO);
    chk("but2_halt_cnt", o_halt, 0);
    chk("but2_busy_len", o_busy, RC + CC + AUTO);
    pif.nBUT2 = 1'b1;
    repeat (60) step();

    // BUT1 with CPU halted -> one RUN pulse.
    pif.cpu_RUNNING = 1'b0;
    clr_counts();
    pif.nBUT1 = 1'b0;
    repeat (50) step();
    chk("but1_run_cnt", o_run, 1);
    chk("but1_run_halt_cnt", o_halt, 0);
    chk("but1_run_busy", o_busy, 0);
    pif.nBUT1 = 1'b1;
    repeat (50) step();

    // BUT1 with CPU running -> one HALT pulse.
    pif.cpu_RUNNING = 1'b1;
    clr_counts();
    pif.nBUT1 = 1'b0;
    repeat (50) step();
    chk("but1_halt_cnt", o_halt, 1);
    chk("but1_halt_run_cnt", o_run, 0);
    pif.nBUT1 = 1'b1;
    repeat (50) step();

    // Glitch of 3 TICK periods is rejected.
    clr_counts();
    pif.nBUT1 = 1'b0;
    repeat (12) step();
    pif.nBUT1 = 1'b1;
    repeat (60) step();
    chk("glitch_activity", o_rst + o_clr + o_run + o_halt + o_busy, 0);

    // Both buttons on the same cycle: BUT2 wins.
    clr_counts();
    pif.nBUT1 = 1'b0;
    pif.nBUT2 = 1'b0;
    repeat (80) step();
    chk("both_reset_len", o_rst, RC);
    chk("both_clear_len", o_clr, CC);
    chk("both_run_cnt", o_run, AUTO);
    chk("both_halt_cnt", o_halt, 0);
    pif.nBUT1 = 1'b1;
    pif.nBUT2 = 1'b1;
    repeat (60) step();

    // RESET on the 4th sw_RESET cycle, button still held.
    pif.nBUT2 = 1'b0;
    k = 0;
    while (pif.sw_RESET !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("midreset_seq_started", {31'd0, k < 100}, 32'd1);
    repeat (3) step();
    chk("midreset_pre_reset_high", {31'd0, pif.sw_RESET}, 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("midreset_outputs", {27'd0, dut_out()}, 32'd0);
    clr_counts();
    repeat (80) step();
    chk("midreset_again_reset_len", o_rst, RC);
    chk("midreset_again_clear_len", o_clr, CC);
    chk("midreset_again_run_cnt", o_run, AUTO);
    pif.nBUT2 = 1'b1;
    repeat (60) step();

    // Randomized buttons, CPU flag, TICK and occasional RESET.
    rand_tick = 1'b1;
    for (int it = 0; it < 50; it++) begin
      pif.nBUT1 = ($urandom_range(0, 2) != 0);
      pif.nBUT2 = ($urandom_range(0, 3) != 0);
      pif.cpu_RUNNING = $urandom_range(0, 1) == 1;
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        RESET = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    RESET = 1'b0;
    rand_tick = 1'b0;
    pif.nBUT1 = 1'b1;
    pif.nBUT2 = 1'b1;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
